// File: rtl/silife_max7219_chain_if.sv
// Bundles the control inputs, the cell-grid row-read port and the MAX7219 chain pins of silife_max7219_chain.
// The master modport is the display driver; the slave modport is the cell grid, the board pins and the control logic.
interface silife_max7219_chain_if #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 32
);
    logic                      i_enable;
    logic [3:0]                i_intensity;
    logic [WIDTH-1:0]          i_cells;
    logic [$clog2(HEIGHT)-1:0] o_row_select;
    logic                      o_cs;
    logic                      o_sck;
    logic                      o_mosi;
    logic                      o_busy;
    logic                      o_frame_done;

    modport master (
        input  i_enable, i_intensity, i_cells,
        output o_row_select, o_cs, o_sck, o_mosi, o_busy, o_frame_done
    );

    modport slave (
        output i_enable, i_intensity, i_cells,
        input  o_row_select, o_cs, o_sck, o_mosi, o_busy, o_frame_done
    );
endinterface

// File: rtl/silife_max7219_chain.sv
// Refreshes a daisy-chained MAX7219 grid from the cell array using SPI mode 0. Every transaction carries one 16-bit word per chip.
// Each bit takes 2*CLK_DIV clk. There is no backpressure: a disable request waits until the current transaction has finished.
module silife_max7219_chain #(
    parameter int WIDTH   = 32,
    parameter int HEIGHT  = 32,
    parameter int CLK_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    silife_max7219_chain_if.master bus
);
    localparam int COLS = WIDTH / 8;
    localparam int ROWS = HEIGHT / 8;
    localparam int N    = COLS * ROWS;
    localparam int TB   = 16 * N;
    localparam int RW   = $clog2(HEIGHT);
    localparam int RBW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int BW   = $clog2(TB);
    localparam int DW   = $clog2(2 * CLK_DIV) + 1;

    localparam logic [DW-1:0]  HALF_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0]  GAP_LAST  = DW'(2 * CLK_DIV - 1);
    localparam logic [BW-1:0]  BIT_LAST  = BW'(TB - 1);
    localparam logic [RBW-1:0] RB_LAST   = RBW'(ROWS - 1);

    typedef enum logic [2:0] {M_IDLE, M_CFG, M_DATA, M_INTEN, M_SHDN} mode_t;
    typedef enum logic [2:0] {P_IDLE, P_PREP, P_START, P_SHIFT, P_HOLD, P_GAP} phase_t;

    mode_t           r_mode;
    phase_t          r_phase;
    logic [2:0]      r_step;
    logic [2:0]      r_digit;
    logic [RBW-1:0]  r_rb;
    logic [1:0]      r_sub;
    logic [DW-1:0]   r_div;
    logic [BW-1:0]   r_bit;
    logic [TB-1:0]   r_buf;
    logic [3:0]      r_int_sent;
    logic [RW-1:0]   r_row_select;
    logic            r_cs;
    logic            r_sck;
    logic            r_mosi;
    logic            r_busy;
    logic            r_frame_done;
    logic [15:0]     w_cmd;

    always_comb begin
        w_cmd = 16'h0000;
        case (r_mode)
            M_CFG: begin
                case (r_step)
                    3'd0:    w_cmd = 16'h0F00;
                    3'd1:    w_cmd = 16'h0B07;
                    3'd2:    w_cmd = 16'h0900;
                    3'd3:    w_cmd = {12'h0A0, bus.i_intensity};
                    default: w_cmd = 16'h0C01;
                endcase
            end
            M_INTEN: w_cmd = {12'h0A0, r_int_sent};
            M_SHDN:  w_cmd = 16'h0C00;
            default: w_cmd = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode       <= M_IDLE;
            r_phase      <= P_IDLE;
            r_step       <= '0;
            r_digit      <= '0;
            r_rb         <= '0;
            r_sub        <= '0;
            r_div        <= '0;
            r_bit        <= '0;
            r_buf        <= '0;
            r_int_sent   <= '0;
            r_row_select <= '0;
            r_cs         <= 1'b1;
            r_sck        <= 1'b0;
            r_mosi       <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_phase)
                P_IDLE: begin
                    if (bus.i_enable) begin
                        r_mode  <= M_CFG;
                        r_step  <= '0;
                        r_busy  <= 1'b1;
                        r_sub   <= '0;
                        r_rb    <= '0;
                        r_phase <= P_PREP;
                    end
                end
                P_PREP: begin
                    if (r_mode == M_DATA) begin
                        // Each chip-row read: select the row, give the grid one clk to respond, then capture.
                        case (r_sub)
                            2'd0: begin
                                r_row_select <= RW'(int'(r_rb) * 8 + int'(r_digit));
                                r_sub        <= 2'd1;
                            end
                            2'd1: r_sub <= 2'd2;
                            default: begin
                                for (int k = 0; k < N; k++) begin
                                    if (k / COLS == int'(r_rb)) begin
                                        r_buf[k*16 +: 16] <= {4'h0, {1'b0, r_digit} + 4'd1,
                                                              bus.i_cells[(k % COLS)*8 +: 8]};
                                    end
                                end
                                r_sub <= 2'd0;
                                if (r_rb == RB_LAST) begin
                                    r_rb    <= '0;
                                    r_phase <= P_START;
                                end else begin
                                    r_rb <= r_rb + 1'b1;
                                end
                            end
                        endcase
                    end else begin
                        r_buf <= {N{w_cmd}};
                        if (r_mode == M_CFG && r_step == 3'd3) begin
                            r_int_sent <= bus.i_intensity;
                        end
                        r_phase <= P_START;
                    end
                end
                P_START: begin
                    r_cs    <= 1'b0;
                    r_sck   <= 1'b0;
                    r_mosi  <= r_buf[TB-1];
                    r_div   <= '0;
                    r_bit   <= '0;
                    r_phase <= P_SHIFT;
                end
                P_SHIFT: begin
                    if (r_div != HALF_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_sck) begin
                            r_sck <= 1'b1;
                        end else begin
                            r_sck <= 1'b0;
                            if (r_bit == BIT_LAST) begin
                                r_phase <= P_HOLD;
                            end else begin
                                r_bit  <= r_bit + 1'b1;
                                r_mosi <= r_buf[TB-2];
                                r_buf  <= {r_buf[TB-2:0], 1'b0};
                            end
                        end
                    end
                end
                P_HOLD: begin
                    if (r_div != HALF_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div   <= '0;
                        r_cs    <= 1'b1;
                        r_mosi  <= 1'b0;
                        r_phase <= P_GAP;
                    end
                end
                P_GAP: begin
                    if (r_div != GAP_LAST) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div   <= '0;
                        r_sub   <= '0;
                        r_rb    <= '0;
                        r_phase <= P_PREP;
                        if (r_mode == M_DATA && r_digit == 3'd7) begin
                            r_frame_done <= 1'b1;
                        end
                        // Shutdown takes priority over every other next step, including a pending intensity update.
                        if (r_mode == M_SHDN) begin
                            r_mode  <= M_IDLE;
                            r_phase <= P_IDLE;
                            r_busy  <= 1'b0;
                        end else if (!bus.i_enable) begin
                            r_mode <= M_SHDN;
                        end else begin
                            case (r_mode)
                                M_CFG: begin
                                    if (r_step == 3'd4) begin
                                        r_mode  <= M_DATA;
                                        r_digit <= '0;
                                    end else begin
                                        r_step <= r_step + 1'b1;
                                    end
                                end
                                M_DATA: begin
                                    if (r_digit != 3'd7) begin
                                        r_digit <= r_digit + 1'b1;
                                    end else begin
                                        r_digit <= '0;
                                        if (bus.i_intensity != r_int_sent) begin
                                            r_int_sent <= bus.i_intensity;
                                            r_mode     <= M_INTEN;
                                        end
                                    end
                                end
                                default: begin
                                    r_mode  <= M_DATA;
                                    r_digit <= '0;
                                end
                            endcase
                        end
                    end
                end
                default: r_phase <= P_IDLE;
            endcase
        end
    end

    assign bus.o_row_select = r_row_select;
    assign bus.o_cs         = r_cs;
    assign bus.o_sck        = r_sck;
    assign bus.o_mosi       = r_mosi;
    assign bus.o_busy       = r_busy;
    assign bus.o_frame_done = r_frame_done;
endmodule
